// File: rtl/lamp_sequence_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lamp_sequence_monitor                                            |
// | Brief   : Decodes six lamp outputs into a phase and checks phase order,    |
// |           phase durations and conflicting lamp patterns (sticky errors).   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module lamp_sequence_monitor #(
  parameter int YELLOW_CYCLES = 5,
  parameter int MIN_GREEN     = 10,
  parameter int CNT_W         = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Ga,
  input  logic             Ya,
  input  logic             Ra,
  input  logic             Gb,
  input  logic             Yb,
  input  logic             Rb,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] last_dur,
  output logic             dur_valid,
  output logic [15:0]      cycle_count,
  output logic             err_conflict,
  output logic             err_order,
  output logic             err_timing
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_yellow  = CNT_W'(YELLOW_CYCLES);
  localparam logic [CNT_W-1:0] c_green   = CNT_W'(MIN_GREEN);

  typedef enum logic [1:0] {
    ST_UNSYNC     = 2'd0,
    ST_SYNC_FIRST = 2'd1,
    ST_SYNC       = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ga, r_ya, r_ra, r_gb, r_yb, r_rb;

  logic             w_ag, w_ay, w_bg, w_by;
  logic             w_legal;
  logic [1:0]       w_new_phase;
  logic [1:0]       w_next_phase;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timing_bad;

  assign w_ag = r_ga & ~r_ya & ~r_ra & r_rb & ~r_gb & ~r_yb;
  assign w_ay = r_ya & ~r_ga & ~r_ra & r_rb & ~r_gb & ~r_yb;
  assign w_bg = r_gb & ~r_yb & ~r_rb & r_ra & ~r_ga & ~r_ya;
  assign w_by = r_yb & ~r_gb & ~r_rb & r_ra & ~r_ga & ~r_ya;

  assign w_legal      = w_ag | w_ay | w_bg | w_by;
  assign w_new_phase  = w_ay ? 2'd1 : w_bg ? 2'd2 : w_by ? 2'd3 : 2'd0;
  assign w_next_phase = phase + 2'd1;
  assign w_cnt_inc    = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;

  // Odd phases are yellow (exact duration), even phases are green (minimum).
  assign w_timing_bad = phase[0] ? (r_cnt != c_yellow) : (r_cnt < c_green);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ga         <= 1'b0;
      r_ya         <= 1'b0;
      r_ra         <= 1'b0;
      r_gb         <= 1'b0;
      r_yb         <= 1'b0;
      r_rb         <= 1'b0;
      r_state      <= ST_UNSYNC;
      r_cnt        <= '0;
      phase        <= 2'd0;
      phase_valid  <= 1'b0;
      last_dur     <= '0;
      dur_valid    <= 1'b0;
      cycle_count  <= 16'd0;
      err_conflict <= 1'b0;
      err_order    <= 1'b0;
      err_timing   <= 1'b0;
    end else begin
      r_ga      <= Ga;
      r_ya      <= Ya;
      r_ra      <= Ra;
      r_gb      <= Gb;
      r_yb      <= Yb;
      r_rb      <= Rb;
      dur_valid <= 1'b0;

      // Set conditions below are later assignments, so they win over a clear.
      if (clr_err) begin
        err_conflict <= 1'b0;
        err_order    <= 1'b0;
        err_timing   <= 1'b0;
      end

      case (r_state)
        ST_UNSYNC: begin
          if (w_legal) begin
            r_state     <= ST_SYNC_FIRST;
            phase       <= w_new_phase;
            phase_valid <= 1'b1;
            r_cnt       <= c_cnt_one;
          end
        end
        ST_SYNC_FIRST, ST_SYNC: begin
          if (!w_legal) begin
            err_conflict <= 1'b1;
            r_state      <= ST_UNSYNC;
            phase_valid  <= 1'b0;
            r_cnt        <= '0;
          end else if (w_new_phase == phase) begin
            r_cnt <= w_cnt_inc;
          end else begin
            last_dur  <= r_cnt;
            dur_valid <= 1'b1;
            r_cnt     <= c_cnt_one;
            phase     <= w_new_phase;
            r_state   <= ST_SYNC;
            if (w_new_phase != w_next_phase) begin
              err_order <= 1'b1;
            end
            // The first synced phase was only partially observed.
            if ((r_state == ST_SYNC) && w_timing_bad) begin
              err_timing <= 1'b1;
            end
            if ((phase == 2'd3) && (w_new_phase == 2'd0)) begin
              cycle_count <= cycle_count + 16'd1;
            end
          end
        end
        default: begin
          r_state     <= ST_UNSYNC;
          phase_valid <= 1'b0;
          r_cnt       <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lamp_sequence_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_lamp_sequence_monitor                                         |
// | Brief   : Self-checking bench; lamp stimulus as (pattern, length) segments |
// |           against a segment-level reference model.                         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_lamp_sequence_monitor;

  localparam int YELLOW_CYCLES = 5;
  localparam int MIN_GREEN     = 10;
  localparam int CNT_W         = 13;
  localparam int DUR_MAX       = (1 << CNT_W) - 1;

  // Lamp bit order {Ga,Ya,Ra,Gb,Yb,Rb}
  localparam logic [5:0] P_AG = 6'b100001;
  localparam logic [5:0] P_AY = 6'b010001;
  localparam logic [5:0] P_BG = 6'b001100;
  localparam logic [5:0] P_BY = 6'b001010;
  localparam logic [5:0] P_GG = 6'b100100;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [5:0]       lamps = 6'b0;
  logic             clr_err = 1'b0;
  logic [1:0]       phase;
  logic             phase_valid;
  logic [CNT_W-1:0] last_dur;
  logic             dur_valid;
  logic [15:0]      cycle_count;
  logic             err_conflict, err_order, err_timing;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state, updated once per segment
  bit m_synced, m_first;
  int m_cur, m_run, m_last_dur, m_cyc;
  bit m_econf, m_eord, m_etim;

  lamp_sequence_monitor #(
    .YELLOW_CYCLES(YELLOW_CYCLES),
    .MIN_GREEN    (MIN_GREEN),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Ga          (lamps[5]),
    .Ya          (lamps[4]),
    .Ra          (lamps[3]),
    .Gb          (lamps[2]),
    .Yb          (lamps[1]),
    .Rb          (lamps[0]),
    .clr_err     (clr_err),
    .phase       (phase),
    .phase_valid (phase_valid),
    .last_dur    (last_dur),
    .dur_valid   (dur_valid),
    .cycle_count (cycle_count),
    .err_conflict(err_conflict),
    .err_order   (err_order),
    .err_timing  (err_timing)
  );

  always #5 clk = ~clk;

  function automatic int classify(logic [5:0] p);
    if (p == P_AG) return 0;
    if (p == P_AY) return 1;
    if (p == P_BG) return 2;
    if (p == P_BY) return 3;
    return -1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_synced   = 0;
    m_first    = 0;
    m_cur      = 0;
    m_run      = 0;
    m_last_dur = 0;
    m_cyc      = 0;
    m_econf    = 0;
    m_eord     = 0;
    m_etim     = 0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_outs"}, {phase, phase_valid, last_dur, dur_valid, cycle_count,
                           err_conflict, err_order, err_timing}, 32'd0);
  endtask

  // Hold one lamp pattern for n (>=2) cycles; clr pulses clr_err on the edge
  // where the monitor first evaluates this pattern.
  task automatic apply_seg(logic [5:0] pat, int n, bit clr);
    int p;
    bit pulse;
    p     = classify(pat);
    pulse = 0;
    if (clr) begin
      m_econf = 0;
      m_eord  = 0;
      m_etim  = 0;
    end
    if (!m_synced) begin
      if (p >= 0) begin
        m_synced = 1;
        m_first  = 1;
        m_cur    = p;
        m_run    = n;
      end
    end else if (p < 0) begin
      m_econf  = 1;
      m_synced = 0;
    end else if (p == m_cur) begin
      m_run += n;
    end else begin
      pulse      = 1;
      m_last_dur = (m_run > DUR_MAX) ? DUR_MAX : m_run;
      if (p != (m_cur + 1) % 4) m_eord = 1;
      if (!m_first && (((m_cur % 2) == 1 && m_run != YELLOW_CYCLES) ||
                       ((m_cur % 2) == 0 && m_run < MIN_GREEN))) m_etim = 1;
      if (m_cur == 3 && p == 0) m_cyc = (m_cyc + 1) % 65536;
      m_cur   = p;
      m_run   = n;
      m_first = 0;
    end

    lamps = pat;
    @(posedge clk); #1;
    clr_err = clr;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("dur_valid", dur_valid, pulse);
    check("phase_valid", phase_valid, m_synced);
    if (m_synced) check("phase", phase, m_cur);
    check("last_dur", last_dur, m_last_dur);
    check("cycle_count", cycle_count, m_cyc);
    check("err_conflict", err_conflict, m_econf);
    check("err_order", err_order, m_eord);
    check("err_timing", err_timing, m_etim);
    for (int i = 2; i < n; i++) begin
      @(posedge clk); #1;
      check("dur_valid_hold", dur_valid, 1'b0);
    end
  endtask

  initial begin
    logic [5:0] pat;
    int         p, n, r;

    // T1: outputs stay zero while reset is held, regardless of lamps
    model_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      lamps = 6'($urandom_range(0, 63));
      clr_err = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_all_zero("reset_hold");
    end
    lamps   = 6'b0;
    clr_err = 1'b0;
    reset   = 1'b1;

    // T2: legal loop, partial first AG
    apply_seg(P_AG, 20, 0);
    apply_seg(P_AY, 5, 0);
    apply_seg(P_BG, 20, 0);
    apply_seg(P_BY, 5, 0);
    apply_seg(P_AG, 20, 0);
    apply_seg(P_AY, 5, 0);

    // T3: short yellow
    apply_seg(P_BG, 20, 0);
    apply_seg(P_BY, 5, 0);
    apply_seg(P_AG, 20, 0);
    apply_seg(P_AY, 4, 0);
    apply_seg(P_BG, 20, 0);
    apply_seg(P_BY, 5, 1);

    // T4: skipped yellow
    apply_seg(P_AG, 20, 0);
    apply_seg(P_BG, 20, 0);

    // T5: conflict then resync
    apply_seg(P_GG, 3, 1);
    apply_seg(P_AG, 20, 1);
    apply_seg(P_AY, 5, 0);

    // T6: saturation, then clear coincident with a new order error
    apply_seg(P_BG, 20, 0);
    apply_seg(P_BY, 5, 0);
    apply_seg(P_AG, 9000, 0);
    apply_seg(P_AY, 5, 0);
    apply_seg(P_BG, 3, 0);
    apply_seg(P_BY, 5, 0);
    apply_seg(P_BG, 20, 1);

    // Randomized segments
    for (int s = 0; s < 80; s++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        p   = m_synced ? (m_cur + 1) % 4 : $urandom_range(0, 3);
        pat = (p == 0) ? P_AG : (p == 1) ? P_AY : (p == 2) ? P_BG : P_BY;
      end else if (r < 80) begin
        p   = $urandom_range(0, 3);
        pat = (p == 0) ? P_AG : (p == 1) ? P_AY : (p == 2) ? P_BG : P_BY;
      end else if (r < 87) begin
        p   = -1;
        pat = 6'b0;
      end else begin
        p = 0;
        while (p >= 0) begin
          pat = 6'($urandom_range(0, 63));
          p   = classify(pat);
        end
      end
      if (p < 0)                n = $urandom_range(2, 6);
      else if ((p % 2) == 1)    n = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 7) : YELLOW_CYCLES;
      else                      n = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 9) : $urandom_range(10, 30);
      apply_seg(pat, n, $urandom_range(0, 7) == 0);
    end

    // Asynchronous reset mid-operation, then resync
    apply_seg(P_AG, 12, 0);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    lamps = 6'b0;
    @(posedge clk); #1;
    model_reset();
    reset = 1'b1;
    apply_seg(P_AY, 5, 0);
    apply_seg(P_BG, 15, 0);
    apply_seg(P_BY, 5, 0);
    apply_seg(P_AG, 10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
